// File: rtl/cnn_acc_sat_22s_14s.sv
// Accumulates N_TERMS signed products plus a bias, then rounds, optionally ReLUs and saturates the sum.
// Result is held in a one-entry output buffer; the product stream stalls only while that buffer is full and not draining.
module cnn_acc_sat_22s_14s #(
   parameter int PROD_WIDTH = 22,
   parameter int ACC_WIDTH  = 32,
   parameter int OUT_WIDTH  = 14,
   parameter int SHIFT      = 7,
   parameter int N_TERMS    = 25,
   parameter int RELU       = 1
) (
   input  logic                  ap_clk,
   input  logic                  ap_rst_n,
   input  logic                  prod_valid,
   output logic                  prod_ready,
   input  logic [PROD_WIDTH-1:0] prod_data,
   input  logic                  prod_last,
   input  logic [OUT_WIDTH-1:0]  bias,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [OUT_WIDTH-1:0]  out_data,
   output logic                  out_ovf,
   output logic                  err_last
);

   localparam int CNT_W = (N_TERMS > 1) ? $clog2(N_TERMS) : 1;
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N_TERMS - 1);
   localparam logic signed [ACC_WIDTH:0] HALF  = (ACC_WIDTH+1)'(1 << (SHIFT - 1));
   localparam logic signed [ACC_WIDTH:0] MAX_V = (ACC_WIDTH+1)'((1 << (OUT_WIDTH - 1)) - 1);
   localparam logic signed [ACC_WIDTH:0] MIN_V = ~MAX_V;

   logic [CNT_W-1:0]            cnt_q, cnt_d;
   logic signed [ACC_WIDTH-1:0] acc_q, acc_d;
   logic                        out_valid_q, out_valid_d;
   logic [OUT_WIDTH-1:0]        out_data_q, out_data_d;
   logic                        out_ovf_q, out_ovf_d;
   logic                        err_last_q, err_last_d;

   logic signed [ACC_WIDTH-1:0] bias_ext, prod_ext, acc_next;
   logic signed [ACC_WIDTH:0]   rnd_sum, rnd_r;
   logic                        beat, is_last, close;
   logic [OUT_WIDTH-1:0]        res_data;
   logic                        res_ovf;

   assign prod_ready = !out_valid_q || out_ready;
   assign beat       = prod_valid && prod_ready;
   assign is_last    = (cnt_q == LAST_CNT);
   assign close      = beat && is_last;

   // Bias is Q6.8; shifting it up aligns it with the Q7.15 products.
   assign bias_ext = ACC_WIDTH'($signed(bias)) <<< SHIFT;
   assign prod_ext = ACC_WIDTH'($signed(prod_data));
   assign acc_next = (cnt_q == '0) ? (bias_ext + prod_ext) : (acc_q + prod_ext);

   // One extra bit keeps the rounding offset from wrapping a near-full sum.
   assign rnd_sum = (ACC_WIDTH+1)'(acc_next) + HALF;
   assign rnd_r   = rnd_sum >>> SHIFT;

   always_comb begin
      res_data = rnd_r[OUT_WIDTH-1:0];
      res_ovf  = 1'b0;
      if (RELU != 0 && rnd_r[ACC_WIDTH]) begin
         res_data = '0;
      end else if (rnd_r > MAX_V) begin
         res_data = MAX_V[OUT_WIDTH-1:0];
         res_ovf  = 1'b1;
      end else if (rnd_r < MIN_V) begin
         res_data = MIN_V[OUT_WIDTH-1:0];
         res_ovf  = 1'b1;
      end
   end

   always_comb begin
      cnt_d       = cnt_q;
      acc_d       = acc_q;
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      out_ovf_d   = out_ovf_q;
      err_last_d  = err_last_q;
      if (beat) begin
         acc_d = acc_next;
         cnt_d = is_last ? '0 : cnt_q + 1'b1;
         if (prod_last != is_last) begin
            err_last_d = 1'b1;
         end
      end
      if (out_valid_q && out_ready) begin
         out_valid_d = 1'b0;
      end
      if (close) begin
         out_valid_d = 1'b1;
         out_data_d  = res_data;
         out_ovf_d   = res_ovf;
      end
   end

   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
         cnt_q       <= '0;
         acc_q       <= '0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_ovf_q   <= 1'b0;
         err_last_q  <= 1'b0;
      end else begin
         cnt_q       <= cnt_d;
         acc_q       <= acc_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_ovf_q   <= out_ovf_d;
         err_last_q  <= err_last_d;
      end
   end

   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign out_ovf   = out_ovf_q;
   assign err_last  = err_last_q;

endmodule

// File: tb/tb_cnn_acc_sat_22s_14s.sv
// Drives a linear (RELU=0) and a ReLU (RELU=1) instance with N_TERMS=4 from the same stream
// and compares both against a queue-based arithmetic model of the group sum.
module tb_cnn_acc_sat_22s_14s;

   logic        ap_clk = 1'b0;
   logic        ap_rst_n;
   logic        prod_valid;
   logic [21:0] prod_data;
   logic        prod_last;
   logic [13:0] bias;
   logic        out_ready;

   logic        prod_ready0, out_valid0, out_ovf0, err_last0;
   logic [13:0] out_data0;
   logic        prod_ready1, out_valid1, out_ovf1, err_last1;
   logic [13:0] out_data1;

   always #5 ap_clk = ~ap_clk;

   cnn_acc_sat_22s_14s #(.N_TERMS(4), .RELU(0)) u_lin (
      .ap_clk(ap_clk), .ap_rst_n(ap_rst_n),
      .prod_valid(prod_valid), .prod_ready(prod_ready0), .prod_data(prod_data),
      .prod_last(prod_last), .bias(bias),
      .out_valid(out_valid0), .out_ready(out_ready), .out_data(out_data0),
      .out_ovf(out_ovf0), .err_last(err_last0));

   cnn_acc_sat_22s_14s #(.N_TERMS(4), .RELU(1)) u_relu (
      .ap_clk(ap_clk), .ap_rst_n(ap_rst_n),
      .prod_valid(prod_valid), .prod_ready(prod_ready1), .prod_data(prod_data),
      .prod_last(prod_last), .bias(bias),
      .out_valid(out_valid1), .out_ready(out_ready), .out_data(out_data1),
      .out_ovf(out_ovf1), .err_last(err_last1));

   typedef struct {
      logic [13:0] d;
      logic        o;
   } res_t;

   res_t   q_lin[$];
   res_t   q_relu[$];
   int     cnt_m;
   longint acc_m;
   bit     err_m;
   bit     fired;
   int     n_chk = 0;
   int     n_err = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Round half up to Q6.8, then ReLU or saturate to 14 bits.
   function automatic res_t model_res(input longint s, input bit relu);
      res_t   r;
      longint v;
      v = s + 64;
      v = (v >= 0) ? (v / 128) : -((-v + 127) / 128);
      r.o = 1'b0;
      if (relu && v < 0) r.d = 14'd0;
      else if (v > 8191) begin r.d = 14'h1FFF; r.o = 1'b1; end
      else if (v < -8192) begin r.d = 14'h2000; r.o = 1'b1; end
      else r.d = 14'(v);
      return r;
   endfunction

   task automatic model_clear();
      q_lin.delete();
      q_relu.delete();
      cnt_m = 0;
      acc_m = 0;
      err_m = 0;
   endtask

   // One clock: check outputs at the falling edge, advance the model, return just after the rising edge.
   task automatic step();
      bit full, fire, ofire;
      @(negedge ap_clk);
      full = (q_lin.size() != 0);
      chk("lin_valid", 32'(out_valid0), 32'(full));
      chk("relu_valid", 32'(out_valid1), 32'(full));
      chk("lin_ready", 32'(prod_ready0), 32'(!full || out_ready));
      chk("relu_ready", 32'(prod_ready1), 32'(!full || out_ready));
      chk("lin_err", 32'(err_last0), 32'(err_m));
      chk("relu_err", 32'(err_last1), 32'(err_m));
      if (full) begin
         chk("lin_data", 32'(out_data0), 32'(q_lin[0].d));
         chk("lin_ovf", 32'(out_ovf0), 32'(q_lin[0].o));
         chk("relu_data", 32'(out_data1), 32'(q_relu[0].d));
         chk("relu_ovf", 32'(out_ovf1), 32'(q_relu[0].o));
      end
      fire  = prod_valid && (!full || out_ready);
      ofire = full && out_ready;
      if (ofire) begin
         void'(q_lin.pop_front());
         void'(q_relu.pop_front());
      end
      if (fire) begin
         if (cnt_m == 0) acc_m = longint'($signed(bias)) * 128;
         acc_m = acc_m + longint'($signed(prod_data));
         if (prod_last != (cnt_m == 3)) err_m = 1;
         if (cnt_m == 3) begin
            q_lin.push_back(model_res(acc_m, 1'b0));
            q_relu.push_back(model_res(acc_m, 1'b1));
            cnt_m = 0;
         end else begin
            cnt_m++;
         end
      end
      fired = fire;
      @(posedge ap_clk);
      #1;
   endtask

   task automatic send_beat(input logic [21:0] d, input bit last, input bit rnd_rdy);
      prod_valid = 1'b1;
      prod_data  = d;
      prod_last  = last;
      fired = 0;
      for (int i = 0; i < 40 && !fired; i++) begin
         if (rnd_rdy) out_ready = (i > 20) ? 1'b1 : 1'($urandom_range(0, 1));
         step();
      end
      if (!fired) chk("beat_timeout", 32'd0, 32'd1);
      prod_valid = 1'b0;
   endtask

   task automatic send_group(input logic [13:0] b, input logic [21:0] d0, input logic [21:0] d1,
                             input logic [21:0] d2, input logic [21:0] d3, input int last_at);
      bias = b;
      send_beat(d0, last_at == 0, 0);
      send_beat(d1, last_at == 1, 0);
      send_beat(d2, last_at == 2, 0);
      send_beat(d3, last_at == 3, 0);
   endtask

   task automatic drain();
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) step();
   endtask

   task automatic async_reset();
      prod_valid = 1'b0;
      ap_rst_n   = 1'b0;
      #2;
      model_clear();
      chk("rst_lin_valid", 32'(out_valid0), 32'd0);
      chk("rst_relu_valid", 32'(out_valid1), 32'd0);
      chk("rst_lin_data", 32'(out_data0), 32'd0);
      chk("rst_lin_ovf", 32'(out_ovf0), 32'd0);
      chk("rst_lin_err", 32'(err_last0), 32'd0);
      chk("rst_relu_err", 32'(err_last1), 32'd0);
      chk("rst_ready", 32'(prod_ready0), 32'd1);
      @(posedge ap_clk);
      #1;
      ap_rst_n = 1'b1;
   endtask

   initial begin
      ap_rst_n   = 1'b0;
      prod_valid = 1'b0;
      prod_data  = '0;
      prod_last  = 1'b0;
      bias       = '0;
      out_ready  = 1'b1;
      model_clear();
      #1;
      chk("reset_valid", 32'(out_valid0), 32'd0);
      chk("reset_ready", 32'(prod_ready0), 32'd1);
      chk("reset_data", 32'(out_data0), 32'd0);
      chk("reset_err", 32'(err_last0), 32'd0);
      @(posedge ap_clk);
      #1;
      ap_rst_n = 1'b1;

      // Basic sum, saturation both ways, ReLU on a negative bias, rounding edges.
      send_group(14'h0100, 22'd16384, 22'd16384, 22'd16384, 22'd16384, 3);
      drain();
      send_group(14'h0000, 22'h1FFFFF, 22'h1FFFFF, 22'h1FFFFF, 22'h1FFFFF, 3);
      send_group(14'h0000, 22'h200000, 22'h200000, 22'h200000, 22'h200000, 3);
      send_group(14'h3F00, 22'd0, 22'd0, 22'd0, 22'd0, 3);
      send_group(14'h0000, 22'd64, 22'd0, 22'd0, 22'd0, 3);
      send_group(14'h0000, 22'd63, 22'd0, 22'd0, 22'd0, 3);
      send_group(14'h0000, -22'sd64, 22'd0, 22'd0, 22'd0, 3);
      send_group(14'h0000, -22'sd65, 22'd0, 22'd0, 22'd0, 3);
      drain();

      // Backpressure: hold the first result, stall the next group's first beat, then release.
      out_ready = 1'b0;
      send_group(14'h0040, 22'd1000, 22'd2000, 22'd3000, 22'd4000, 3);
      prod_valid = 1'b1;
      prod_data  = 22'd5000;
      prod_last  = 1'b0;
      bias       = 14'h0010;
      for (int i = 0; i < 4; i++) begin
         step();
         chk("bp_stall", 32'(fired), 32'd0);
      end
      out_ready = 1'b1;
      send_beat(22'd5000, 0, 0);
      send_beat(22'd6000, 0, 0);
      send_beat(22'd7000, 0, 0);
      send_beat(22'd8000, 1, 0);
      drain();

      // prod_last on the wrong beat flags err_last but the group still closes on count.
      send_group(14'h0020, 22'd300, 22'd400, 22'd500, 22'd600, 1);
      drain();

      for (int g = 0; g < 60; g++) begin
         bias = 14'($urandom);
         for (int b = 0; b < 4; b++) begin
            logic [21:0] d;
            bit          lst;
            if ($urandom_range(0, 3) == 0) d = 22'($urandom);
            else d = 22'(int'($urandom_range(0, 32767)) - 16384);
            lst = (b == 3);
            if ($urandom_range(0, 15) == 0) lst = !lst;
            if ($urandom_range(0, 3) == 0) begin
               out_ready = 1'($urandom_range(0, 1));
               step();
            end
            send_beat(d, lst, 1);
         end
      end
      drain();

      // Reset while a result is pending, then reset mid-group and confirm the partial sum is gone.
      out_ready = 1'b0;
      send_group(14'h0100, 22'd9000, 22'd9000, 22'd9000, 22'd9000, 3);
      step();
      async_reset();
      out_ready = 1'b1;
      bias = 14'h0200;
      send_beat(22'd50000, 0, 0);
      send_beat(22'd50000, 0, 0);
      async_reset();
      send_group(14'h0001, 22'd256, 22'd512, 22'd768, 22'd1024, 3);
      drain();

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
